// File: rtl/icache_refill_ctrl_pkg.sv
// Shared geometry and FSM encoding for the instruction-cache refill controller.
package icache_refill_ctrl_pkg;

  localparam int ISET_INDEX_SIZE  = 6;
  localparam int IBLOCK_WORDS     = 4;
  localparam int IWORD_OFF_W      = $clog2(IBLOCK_WORDS);
  localparam int ITAG_SIZE        = 32 - ISET_INDEX_SIZE - IWORD_OFF_W - 2;
  localparam int IBLOCK_SIZE_BITS = IBLOCK_WORDS * 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } refill_state_e;

endpackage

// File: rtl/icache_fill_buffer.sv
// Collects in-order memory beats into one cache block; last_beat flags the final word.
module icache_fill_buffer
  import icache_refill_ctrl_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = IBLOCK_WORDS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          beat_en,
  input  logic [WORD_W-1:0]             beat_data,
  output logic                          last_beat,
  output logic [BLOCK_WORDS*WORD_W-1:0] block
);

  localparam int BEAT_W = $clog2(BLOCK_WORDS);

  logic [BEAT_W-1:0] beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat  <= '0;
      block <= '0;
    end else if (clear) begin
      beat  <= '0;
      block <= '0;
    end else if (beat_en) begin
      block[beat*WORD_W +: WORD_W] <= beat_data;
      beat                         <= beat + BEAT_W'(1);
    end
  end

  assign last_beat = (beat == BEAT_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// Fetch-side lookup plus miss refill: burst a block from memory, then write it to the SRAM once.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = IBLOCK_WORDS,
  parameter int INDEX_W     = ISET_INDEX_SIZE,
  parameter int TAG_W       = ADDR_W - INDEX_W - $clog2(BLOCK_WORDS) - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  input  logic [ADDR_W-1:0]             pc,
  output logic [WORD_W-1:0]             instr,
  output logic                          instr_valid,
  output logic                          stall,
  output logic                          sram_en,
  output logic                          sram_wen,
  output logic [TAG_W+INDEX_W-1:0]      sram_block_addr,
  output logic [BLOCK_WORDS*WORD_W-1:0] sram_data_in,
  input  logic                          sram_hit,
  input  logic [BLOCK_WORDS*WORD_W-1:0] sram_data_out,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ready,
  input  logic [WORD_W-1:0]             mem_rdata,
  output logic [15:0]                   miss_count
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int BA_W  = TAG_W + INDEX_W;
  localparam int BLK_W = BLOCK_WORDS * WORD_W;

  refill_state_e     state;
  logic [BA_W-1:0]   blk_addr_q;
  logic              mem_req_q;
  logic              wen_q;
  logic [15:0]       miss_cnt;

  logic [BA_W-1:0]   pc_blk;
  logic [OFF_W-1:0]  pc_off;
  logic              idle;
  logic              miss;
  logic              beat_en;
  logic              last_beat;
  logic [BLK_W-1:0]  fill_block;
  logic              unused_pc_lsb;

  assign pc_blk        = pc[ADDR_W-1 -: BA_W];
  assign pc_off        = pc[OFF_W+1:2];
  assign unused_pc_lsb = ^pc[1:0];
  assign idle          = (state == S_IDLE);
  assign miss          = idle & fetch_en & ~sram_hit;
  assign beat_en       = (state == S_FILL) & mem_ready;

  icache_fill_buffer #(
    .WORD_W      (WORD_W),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_fill_buffer (
    .clk       (clk),
    .rst       (rst),
    .clear     (miss),
    .beat_en   (beat_en),
    .beat_data (mem_rdata),
    .last_beat (last_beat),
    .block     (fill_block)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      blk_addr_q <= '0;
      mem_req_q  <= 1'b0;
      wen_q      <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss) begin
            state      <= S_FILL;
            blk_addr_q <= pc_blk;
            mem_req_q  <= 1'b1;
          end
        end
        S_FILL: begin
          if (beat_en && last_beat) begin
            state     <= S_WRITE;
            mem_req_q <= 1'b0;
            wen_q     <= 1'b1;
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
          wen_q <= 1'b0;
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
        default: begin
          state     <= S_IDLE;
          mem_req_q <= 1'b0;
          wen_q     <= 1'b0;
        end
      endcase
    end
  end

  // In IDLE the SRAM sees the live pc and its own data looped back, so a hit-cycle write is harmless.
  assign sram_en         = idle ? fetch_en : wen_q;
  assign sram_wen        = wen_q;
  assign sram_block_addr = idle ? pc_blk : blk_addr_q;
  assign sram_data_in    = idle ? sram_data_out : fill_block;

  assign instr       = sram_data_out[pc_off*WORD_W +: WORD_W];
  assign instr_valid = idle & fetch_en & sram_hit;
  assign stall       = ~idle | miss;

  assign mem_req    = mem_req_q;
  assign mem_addr   = {blk_addr_q, {(OFF_W+2){1'b0}}};
  assign miss_count = miss_cnt;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl with a 2-way SRAM environment and an LRU-list reference model.
module tb_icache_refill_ctrl;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int BW     = 4;
  localparam int IDX_W  = 6;
  localparam int TAG_W  = ADDR_W - IDX_W - 2 - 2;
  localparam int BA_W   = TAG_W + IDX_W;
  localparam int BLK_W  = BW * WORD_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_en;
  logic [ADDR_W-1:0] pc;
  logic [WORD_W-1:0] instr;
  logic              instr_valid;
  logic              stall;
  logic              sram_en;
  logic              sram_wen;
  logic [BA_W-1:0]   sram_block_addr;
  logic [BLK_W-1:0]  sram_data_in;
  logic              sram_hit;
  logic [BLK_W-1:0]  sram_data_out;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_rdata;
  logic [15:0]       miss_count;

  int          n_chk;
  int          n_err;
  logic [15:0] m_miss;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en        (fetch_en),
    .pc              (pc),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .stall           (stall),
    .sram_en         (sram_en),
    .sram_wen        (sram_wen),
    .sram_block_addr (sram_block_addr),
    .sram_data_in    (sram_data_in),
    .sram_hit        (sram_hit),
    .sram_data_out   (sram_data_out),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .miss_count      (miss_count)
  );

  // 2-way SRAM environment: combinational lookup, PLRU victim on a write-miss.
  logic             sram_clr;
  logic [TAG_W-1:0] s_tag [2][64];
  logic             s_vld [2][64];
  logic [BLK_W-1:0] s_dat [2][64];
  logic             s_mru [64];
  logic [IDX_W-1:0] s_idx;
  logic [TAG_W-1:0] s_t;
  logic             hit0, hit1, victim;

  assign s_idx         = sram_block_addr[IDX_W-1:0];
  assign s_t           = sram_block_addr[BA_W-1:IDX_W];
  assign hit0          = s_vld[0][s_idx] && (s_tag[0][s_idx] == s_t);
  assign hit1          = s_vld[1][s_idx] && (s_tag[1][s_idx] == s_t);
  assign sram_hit      = sram_en && (hit0 || hit1);
  assign sram_data_out = hit0 ? s_dat[0][s_idx] : (hit1 ? s_dat[1][s_idx] : '0);
  assign victim        = !s_vld[0][s_idx] ? 1'b0 : (!s_vld[1][s_idx] ? 1'b1 : ~s_mru[s_idx]);

  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < 64; i++) begin
        s_vld[0][i] <= 1'b0;
        s_vld[1][i] <= 1'b0;
        s_mru[i]    <= 1'b0;
      end
    end else if (sram_en) begin
      if (hit0 || hit1) begin
        s_mru[s_idx] <= hit1;
      end else if (sram_wen) begin
        s_tag[victim][s_idx] <= s_t;
        s_vld[victim][s_idx] <= 1'b1;
        s_dat[victim][s_idx] <= sram_data_in;
        s_mru[s_idx]         <= victim;
      end
    end
  end

  // Reference model: memory contents and a per-set recency list of resident tags.
  logic [TAG_W-1:0] m_tag [64][2];
  int               m_n   [64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic bit m_lookup(input logic [31:0] a);
    logic [5:0]       ix;
    logic [TAG_W-1:0] t;
    ix = a[9:4];
    t  = a[31:10];
    if (m_n[ix] > 0 && m_tag[ix][0] == t) return 1'b1;
    if (m_n[ix] > 1 && m_tag[ix][1] == t) begin
      m_tag[ix][1] = m_tag[ix][0];
      m_tag[ix][0] = t;
      return 1'b1;
    end
    m_tag[ix][1] = m_tag[ix][0];
    m_tag[ix][0] = t;
    if (m_n[ix] < 2) m_n[ix] = m_n[ix] + 1;
    return 1'b0;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    step();
    fetch_en  = 1'b0;
    pc        = $urandom;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    #1;
    check_eq("idle_stall", 128'(stall), 128'(1'b0));
    check_eq("idle_valid", 128'(instr_valid), 128'(1'b0));
    check_eq("idle_req", 128'(mem_req), 128'(1'b0));
    check_eq("idle_en", 128'(sram_en), 128'(1'b0));
    mem_ready = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a, input int glo, input int ghi, input bit wiggle);
    logic [31:0]  base;
    logic [127:0] blk;
    bit           hit;
    int           beats;
    int           gap;
    int           guard;
    base = {a[31:4], 4'h0};
    hit  = m_lookup(a);
    step();
    fetch_en  = 1'b1;
    pc        = a;
    mem_ready = 1'b0;
    #1;
    if (hit) begin
      check_eq("hit_valid", 128'(instr_valid), 128'(1'b1));
      check_eq("hit_stall", 128'(stall), 128'(1'b0));
      check_eq("hit_instr", 128'(instr), 128'(mem_word(a)));
      check_eq("hit_noreq", 128'(mem_req), 128'(1'b0));
    end else begin
      check_eq("miss_stall", 128'(stall), 128'(1'b1));
      check_eq("miss_valid", 128'(instr_valid), 128'(1'b0));
      for (int i = 0; i < BW; i++) blk[i*32 +: 32] = mem_word(base + 32'(4 * i));
      beats = 0;
      guard = 0;
      gap   = int'($urandom_range(ghi, glo));
      while (beats < BW && guard < 64) begin
        step();
        guard = guard + 1;
        if (wiggle) begin
          pc       = 32'h200;
          fetch_en = 1'($urandom);
        end
        if (gap > 0) begin
          gap       = gap - 1;
          mem_ready = 1'b0;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(base + 32'(4 * beats));
          beats     = beats + 1;
          gap       = int'($urandom_range(ghi, glo));
        end
        #1;
        check_eq("fill_req", 128'(mem_req), 128'(1'b1));
        check_eq("fill_addr", 128'(mem_addr), 128'(base));
        check_eq("fill_stall", 128'(stall), 128'(1'b1));
        check_eq("fill_wen", 128'(sram_wen), 128'(1'b0));
      end
      step();
      fetch_en  = 1'b1;
      pc        = a;
      mem_ready = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      #1;
      if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
      check_eq("wr_wen", 128'(sram_wen), 128'(1'b1));
      check_eq("wr_en", 128'(sram_en), 128'(1'b1));
      check_eq("wr_req", 128'(mem_req), 128'(1'b0));
      check_eq("wr_stall", 128'(stall), 128'(1'b1));
      check_eq("wr_valid", 128'(instr_valid), 128'(1'b0));
      check_eq("wr_data", sram_data_in, blk);
      check_eq("wr_baddr", 128'(sram_block_addr), 128'(base[31:4]));
      step();
      #1;
      check_eq("re_valid", 128'(instr_valid), 128'(1'b1));
      check_eq("re_instr", 128'(instr), 128'(mem_word(a)));
      check_eq("re_stall", 128'(stall), 128'(1'b0));
      check_eq("re_wen", 128'(sram_wen), 128'(1'b0));
      check_eq("re_count", 128'(miss_count), 128'(m_miss));
      mem_ready = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    n_chk     = 0;
    n_err     = 0;
    m_miss    = 16'd0;
    rst       = 1'b0;
    sram_clr  = 1'b1;
    fetch_en  = 1'b0;
    pc        = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 64; i++) m_n[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    sram_clr = 1'b0;
    #1;
    check_eq("rst_req", 128'(mem_req), 128'(1'b0));
    check_eq("rst_wen", 128'(sram_wen), 128'(1'b0));
    check_eq("rst_count", 128'(miss_count), 128'(16'd0));
    check_eq("rst_valid", 128'(instr_valid), 128'(1'b0));
    check_eq("rst_stall", 128'(stall), 128'(1'b0));
    step();
    rst = 1'b1;

    // Reset in the middle of a burst, then a stray beat while idle.
    step();
    fetch_en = 1'b1;
    pc       = 32'h100;
    #1;
    check_eq("ab_stall", 128'(stall), 128'(1'b1));
    step();
    fetch_en  = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h11;
    #1;
    check_eq("ab_req", 128'(mem_req), 128'(1'b1));
    step();
    mem_rdata = 32'h22;
    step();
    mem_ready = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check_eq("ab_rst_req", 128'(mem_req), 128'(1'b0));
    check_eq("ab_rst_stall", 128'(stall), 128'(1'b0));
    check_eq("ab_rst_count", 128'(miss_count), 128'(16'd0));
    step();
    rst = 1'b1;
    step();
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD;
    #1;
    check_eq("ab_stray_req", 128'(mem_req), 128'(1'b0));
    check_eq("ab_stray_stall", 128'(stall), 128'(1'b0));
    mem_ready = 1'b0;

    // Cold miss with back-to-back beats, then a hit on the last word.
    do_fetch(32'h100, 0, 0, 1'b0);
    do_fetch(32'h10C, 0, 0, 1'b0);

    // Gapped burst with pc wandering during the fill, then a set conflict.
    do_fetch(32'h500, 3, 3, 1'b1);
    do_fetch(32'h104, 0, 0, 1'b0);
    do_fetch(32'h908, 1, 2, 1'b0);
    do_fetch(32'h900, 0, 0, 1'b0);
    do_fetch(32'h108, 0, 0, 1'b0);
    do_fetch(32'h504, 0, 1, 1'b0);
    idle_cycle();

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(3, 0) == 0) idle_cycle();
      a = (32'($urandom_range(3, 0)) << 10)
        | ((32'd16 + 32'($urandom_range(3, 0))) << 4)
        | (32'($urandom_range(3, 0)) << 2);
      do_fetch(a, 0, 2, 1'($urandom));
    end

    // Counter saturation: preload just below the ceiling and miss three times.
    step();
    dut.miss_cnt = 16'hFFFE;
    m_miss       = 16'hFFFE;
    do_fetch(32'h5000, 0, 1, 1'b0);
    do_fetch(32'h6004, 0, 1, 1'b0);
    do_fetch(32'h7008, 0, 1, 1'b0);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
